// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing one external memory port between the
//   instruction fetch unit (read-only) and the load/store unit (read/write).
//   One transaction is outstanding at a time; each requester holds req until
//   it sees its one-cycle rvalid pulse.
//
// Ports
//   sys_clk, sys_rst       clock (rising edge), asynchronous active-low reset
//   ifu_req/ifu_addr       fetch request and address
//   ifu_rvalid/ifu_rdata   fetch completion pulse and data
//   lsu_req/lsu_wen/lsu_addr/lsu_wdata/lsu_wmask
//                          load/store request, direction, address, data, mask
//   lsu_rvalid/lsu_rdata   load/store completion pulse and data (0 for stores)
//   mem_req/mem_wen/mem_addr/mem_wdata/mem_wmask
//                          memory request, driven from latched transaction
//   mem_gnt/mem_resp/mem_rdata
//                          memory accept, completion, and read data
//   arb_busy               high whenever the FSM is not idle
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nxt;

  logic owner_lsu;   // owner of the current transaction: 1 = LSU, 0 = IFU
  logic last_lsu;    // last requester served: 1 = LSU, 0 = IFU
  logic ifu_elig, lsu_elig;
  logic grant, pick_lsu, complete;

  // A requester still holding req in its rvalid cycle is not eligible,
  // otherwise it would be re-granted for the transaction it just finished.
  assign ifu_elig = ifu_req & ~ifu_rvalid;
  assign lsu_elig = lsu_req & ~lsu_rvalid;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign pick_lsu = lsu_elig & (~ifu_elig | ~last_lsu);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ifu_elig | lsu_elig) state_nxt = REQ;
      REQ: begin
        if (mem_gnt && mem_resp) state_nxt = IDLE;
        else if (mem_gnt)        state_nxt = WAIT;
      end
      WAIT:    if (mem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == REQ);
    arb_busy = (state != IDLE);
    grant    = (state == IDLE) & (ifu_elig | lsu_elig);
    complete = ((state == REQ) & mem_gnt & mem_resp) | ((state == WAIT) & mem_resp);
  end

  // Transaction latch, pointer, and completion registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      owner_lsu  <= 1'b0;
      last_lsu   <= 1'b1;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      ifu_rvalid <= 1'b0;
      lsu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      lsu_rdata  <= '0;
    end else begin
      if (grant) begin
        owner_lsu <= pick_lsu;
        last_lsu  <= pick_lsu;
        mem_wen   <= pick_lsu & lsu_wen;
        mem_addr  <= pick_lsu ? lsu_addr : ifu_addr;
        mem_wdata <= (pick_lsu & lsu_wen) ? lsu_wdata : '0;
        mem_wmask <= (pick_lsu & lsu_wen) ? lsu_wmask : '0;
      end
      ifu_rvalid <= complete & ~owner_lsu;
      lsu_rvalid <= complete & owner_lsu;
      if (complete) begin
        if (owner_lsu) lsu_rdata <= mem_wen ? '0 : mem_rdata;
        else           ifu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: lone fetch, round-robin ties, wait
//   states on a store, held-request masking, reset mid-WAIT, and a
//   spurious memory response while idle.
module tb_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ifu_req, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_wen, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req, mem_wen, mem_gnt, mem_resp, arb_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    step();
    step();
    sys_rst = 1'b1;
  endtask

  initial begin
    logic        is_lsu;
    logic [31:0] exp_d;

    sys_rst = 1'b0;
    ifu_req = 0; ifu_addr = '0;
    lsu_req = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 0; mem_resp = 0; mem_rdata = '0;
    step();
    step();

    // Reset state
    chk1 ("rst_mem_req",   mem_req,    1'b0);
    chk1 ("rst_busy",      arb_busy,   1'b0);
    chk1 ("rst_ifu_rv",    ifu_rvalid, 1'b0);
    chk1 ("rst_lsu_rv",    lsu_rvalid, 1'b0);
    chk32("rst_mem_addr",  mem_addr,   32'h0);
    chk32("rst_ifu_rdata", ifu_rdata,  32'h0);
    sys_rst = 1'b1;

    // Lone fetch with zero-wait memory
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    chk1("fetch_c0_req", mem_req, 1'b0);
    step();
    chk1 ("fetch_c1_req",   mem_req,   1'b1);
    chk1 ("fetch_c1_busy",  arb_busy,  1'b1);
    chk32("fetch_c1_addr",  mem_addr,  32'h8000_0000);
    chk1 ("fetch_c1_wen",   mem_wen,   1'b0);
    chk32("fetch_c1_wmask", {28'h0, mem_wmask}, 32'h0);
    mem_gnt = 1; mem_resp = 1; mem_rdata = 32'h0000_0413;
    step();
    mem_gnt = 0; mem_resp = 0;
    chk1 ("fetch_c2_rv",    ifu_rvalid, 1'b1);
    chk32("fetch_c2_rdata", ifu_rdata,  32'h0000_0413);
    chk1 ("fetch_c2_lsurv", lsu_rvalid, 1'b0);
    chk1 ("fetch_c2_req",   mem_req,    1'b0);
    chk1 ("fetch_c2_busy",  arb_busy,   1'b0);
    ifu_req = 0;
    step();
    chk1 ("fetch_c3_rv",    ifu_rvalid, 1'b0);
    chk1 ("fetch_c3_req",   mem_req,    1'b0);
    chk32("fetch_c3_rdata", ifu_rdata,  32'h0000_0413);

    // Tie after reset, both held: alternation IFU, LSU, ... over 6 transactions
    do_reset();
    ifu_req = 1; ifu_addr = 32'h0000_1000;
    lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h0000_2000;
    step();
    for (int t = 0; t < 6; t++) begin
      is_lsu = t[0];
      exp_d  = 32'hA0 + 32'(t);
      chk1 ("rr_req",  mem_req, 1'b1);
      chk32("rr_addr", mem_addr, is_lsu ? 32'h0000_2000 : 32'h0000_1000);
      mem_gnt = 1; mem_resp = 1; mem_rdata = exp_d;
      step();
      mem_gnt = 0; mem_resp = 0;
      chk1 ("rr_ifu_rv", ifu_rvalid, ~is_lsu);
      chk1 ("rr_lsu_rv", lsu_rvalid, is_lsu);
      chk32("rr_rdata",  is_lsu ? lsu_rdata : ifu_rdata, exp_d);
      if (t == 5) begin
        ifu_req = 0;
        lsu_req = 0;
      end
      step();
    end
    chk1("rr_idle_req",  mem_req,  1'b0);
    chk1("rr_idle_busy", arb_busy, 1'b0);
    // Last served was LSU, so the next tie goes to IFU
    ifu_req = 1; lsu_req = 1;
    step();
    chk32("rr_tie2_addr", mem_addr, 32'h0000_1000);
    mem_gnt = 1; mem_resp = 1; mem_rdata = 32'h77;
    step();
    mem_gnt = 0; mem_resp = 0;
    chk1("rr_tie2_rv", ifu_rvalid, 1'b1);
    ifu_req = 0; lsu_req = 0;
    step();

    // LSU store with wait states; inputs perturbed after grant
    lsu_req = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    step();
    for (int i = 0; i < 4; i++) begin
      chk1 ("st_req",   mem_req,   1'b1);
      chk1 ("st_wen",   mem_wen,   1'b1);
      chk32("st_addr",  mem_addr,  32'h8000_1000);
      chk32("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk32("st_wmask", {28'h0, mem_wmask}, 32'h0000_000F);
      chk1 ("st_rv",    lsu_rvalid, 1'b0);
      if (i == 0) begin
        lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_wen = 0;
      end
      mem_resp  = (i == 1);
      mem_rdata = 32'h0000_0BAD;
      mem_gnt   = (i == 3);
      step();
    end
    mem_gnt = 0; mem_resp = 0;
    chk1("st_wait1_req",  mem_req,    1'b0);
    chk1("st_wait1_busy", arb_busy,   1'b1);
    chk1("st_wait1_rv",   lsu_rvalid, 1'b0);
    step();
    chk1("st_wait2_req",  mem_req,  1'b0);
    chk1("st_wait2_busy", arb_busy, 1'b1);
    mem_resp = 1; mem_rdata = 32'h5555_5555;
    step();
    mem_resp = 0;
    chk1 ("st_done_rv",    lsu_rvalid, 1'b1);
    chk32("st_done_rdata", lsu_rdata,  32'h0);
    chk1 ("st_done_busy",  arb_busy,   1'b0);
    lsu_req = 0;
    step();
    chk1("st_after_rv", lsu_rvalid, 1'b0);

    // IFU holds req through rvalid: no grant in the rvalid cycle
    ifu_req = 1; ifu_addr = 32'h0000_3000;
    step();
    chk1("hold_c1_req", mem_req, 1'b1);
    mem_gnt = 1; mem_resp = 1; mem_rdata = 32'h11;
    step();
    mem_gnt = 0; mem_resp = 0;
    chk1("hold_c2_rv",  ifu_rvalid, 1'b1);
    chk1("hold_c2_req", mem_req,    1'b0);
    step();
    chk1("hold_c3_rv",   ifu_rvalid, 1'b0);
    chk1("hold_c3_req",  mem_req,    1'b0);
    chk1("hold_c3_busy", arb_busy,   1'b0);
    step();
    chk1 ("hold_c4_req",  mem_req,  1'b1);
    chk32("hold_c4_addr", mem_addr, 32'h0000_3000);
    mem_gnt = 1; mem_resp = 1; mem_rdata = 32'h22;
    step();
    mem_gnt = 0; mem_resp = 0;
    chk1 ("hold_c5_rv",    ifu_rvalid, 1'b1);
    chk32("hold_c5_rdata", ifu_rdata,  32'h22);
    ifu_req = 0;
    step();

    // Reset asserted during WAIT
    ifu_req = 1; ifu_addr = 32'h0000_4000;
    step();
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk1("rw_wait_busy", arb_busy, 1'b1);
    ifu_req = 0;
    #1 sys_rst = 1'b0;
    #1;
    chk1 ("rw_req",       mem_req,    1'b0);
    chk1 ("rw_busy",      arb_busy,   1'b0);
    chk32("rw_addr",      mem_addr,   32'h0);
    chk1 ("rw_wen",       mem_wen,    1'b0);
    chk32("rw_ifu_rdata", ifu_rdata,  32'h0);
    chk1 ("rw_ifu_rv",    ifu_rvalid, 1'b0);
    step();
    step();
    sys_rst = 1'b1;
    mem_resp = 1; mem_rdata = 32'h99;
    step();
    mem_resp = 0;
    chk1 ("rw_post_ifu_rv", ifu_rvalid, 1'b0);
    chk1 ("rw_post_lsu_rv", lsu_rvalid, 1'b0);
    chk32("rw_post_rdata",  ifu_rdata,  32'h0);
    ifu_req = 1; lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h0000_5000;
    step();
    chk32("rw_tie_addr", mem_addr, 32'h0000_4000);
    mem_gnt = 1; mem_resp = 1; mem_rdata = 32'h0000_CAFE;
    step();
    mem_gnt = 0; mem_resp = 0;
    chk1("rw_tie_rv", ifu_rvalid, 1'b1);
    ifu_req = 0; lsu_req = 0;
    step();

    // Spurious mem_resp while idle
    mem_resp = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_resp = 0;
    chk1 ("sp_ifu_rv",    ifu_rvalid, 1'b0);
    chk1 ("sp_lsu_rv",    lsu_rvalid, 1'b0);
    chk32("sp_ifu_rdata", ifu_rdata,  32'h0000_CAFE);
    chk32("sp_lsu_rdata", lsu_rdata,  32'h0);
    chk1 ("sp_busy",      arb_busy,   1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one external memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It sits between IFU/LSU and the memory interface, turning the fixed-latency, per-unit memory model into a multi-cycle, request/grant/response path. Each requester sees a simple hold-until-done handshake. Arbitration is round-robin, with one transaction outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
- sys_clk  in  1  clock, rising edge
- sys_rst  in  1  asynchronous reset, active-low
- ifu_req  in  1  fetch request; held until ifu_rvalid
- ifu_addr  in  ADDR_W  fetch address
- ifu_rvalid  out  1  one-cycle pulse: fetch complete
- ifu_rdata  out  DATA_W  fetch data, valid with ifu_rvalid
- lsu_req  in  1  load/store request; held until lsu_rvalid
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_rvalid  out  1  one-cycle pulse: load or store complete
- lsu_rdata  out  DATA_W  load data, valid with lsu_rvalid; 0 for stores
- mem_req  out  1  request to memory
- mem_wen  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  DATA_W/8  write mask; 0 on reads
- mem_gnt  in  1  memory accepts the request this cycle
- mem_resp  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_resp
- arb_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, no eligible requester: stay in IDLE.
- IDLE, eligible requester present: latch owner, addr, wen, wdata and wmask (wmask forced to 0 for IFU and for LSU loads). Go to REQ.
- REQ: mem_req = 1, and mem_* is driven only from the latched registers.
  - mem_gnt & mem_resp: complete (see below).
  - mem_gnt only: go to WAIT.
  - Otherwise: hold in REQ with the fields stable.
- WAIT: mem_req = 0. On mem_resp, complete.
- Complete: register mem_rdata into the owner's rdata; pulse the owner's rvalid on the next cycle; return to IDLE.
- Eligibility: req = 1 and that requester's rvalid = 0 in the current cycle. This mask stops a requester that is still holding req from being re-granted in the cycle it sees rvalid.
- Round-robin: if both are eligible, grant the one not served last. The last-served pointer updates on each grant and resets to LSU, so IFU wins the first tie.
- A single eligible requester is granted regardless of the pointer.
- Dropping req after grant has no effect: the transaction completes and rvalid still pulses.
- mem_resp in IDLE or REQ-without-gnt is ignored. mem_gnt outside REQ is ignored.
- rdata holds its last value between pulses. lsu_rdata is written as 0 on store completion.

## Timing
- Reset (async assert, deassert synchronous to sys_clk): state IDLE, pointer = LSU. All outputs are 0: mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, arb_busy.
- Reset mid-transaction aborts it with no rvalid pulse, and mem_req falls immediately.
- Latency, with req sampled in IDLE at cycle 0:
  - mem_req is high in cycle 1.
  - If mem_gnt and mem_resp arrive at cycle 1, rvalid is high in cycle 2. This 2-cycle round trip is the minimum.
  - In general, mem_resp at cycle k gives rvalid at k+1, with the state in IDLE at k+1.
- New arbitration can happen in the same cycle that rvalid is high (the state is IDLE). Back-to-back throughput is one transaction per 2 cycles with zero-wait memory.
- arb_busy is high from cycle 1 through the cycle mem_resp is seen.

## Test plan
- Lone fetch: ifu_req=1, addr=0x80000000. Memory gives gnt+resp at cycle 1 with rdata=0x00000413. Required: mem_req high only in cycle 1; ifu_rvalid pulses in cycle 2 with ifu_rdata=0x00000413; lsu_rvalid stays 0.
- Tie after reset: both req raised at cycle 0. Required: IFU is served first; LSU is granted in the cycle ifu_rvalid pulses; the next tie goes to IFU again (alternation over 6 transactions, 3 each).
- Wait states: LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF. mem_gnt is withheld 3 cycles, then mem_resp 2 cycles after gnt. Required: mem_* stable through REQ; lsu_rvalid exactly once; lsu_rdata=0.
- Held req masking: IFU keeps req=1 through and after rvalid while LSU is idle. Required: no grant in the rvalid cycle; a second grant the following cycle.
- Reset mid-WAIT: assert sys_rst low during WAIT. Required: all outputs 0 immediately, no rvalid after release, and a tie then goes to IFU.
- Spurious mem_resp in IDLE with rdata=0x12345678. Required: no rvalid, rdata registers unchanged.
